// File: rtl/fmdsp_pkg.sv
// Shared encodings and helpers for the fracturable DSP multiply / MAC slice.
package fmdsp_pkg;

    // Operand-width modes; encoding 3 behaves like MODE_FF.
    localparam logic [1:0] MODE_HH = 2'd0;
    localparam logic [1:0] MODE_HF = 2'd1;
    localparam logic [1:0] MODE_FF = 2'd2;

    // Core partial-product schemes.
    localparam int unsigned PPM_BW    = 0;
    localparam int unsigned PPM_BOOTH = 1;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    // Number of core-multiplier passes an operation takes in a given mode.
    function automatic logic [2:0] num_passes(input logic [1:0] mode);
        case (mode)
            MODE_HH: num_passes = 3'd1;
            MODE_HF: num_passes = 3'd2;
            default: num_passes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/fmdsp_if.sv
// Operand / control / result bundle of the DSP slice.
interface fmdsp_if #(
    parameter int unsigned WIDTH            = 16,
    parameter int unsigned SHIFT_BITS       = 2,
    parameter int unsigned PIPE_STAGE_WIDTH = 2
);
    logic                        start;
    logic [1:0]                  mode;
    logic [WIDTH-1:0]            aa;
    logic [WIDTH-1:0]            bb;
    logic [2*WIDTH-1:0]          cc;
    logic                        mac;
    logic                        shift_enable;
    logic [SHIFT_BITS-1:0]       shift_amount;
    logic                        shift_dir;
    logic [PIPE_STAGE_WIDTH-1:0] pipe_stages;
    logic [2*WIDTH-1:0]          out;

    modport master (
        output start, mode, aa, bb, cc, mac, shift_enable, shift_amount, shift_dir, pipe_stages,
        input  out
    );

    modport slave (
        input  start, mode, aa, bb, cc, mac, shift_enable, shift_amount, shift_dir, pipe_stages,
        output out
    );
endinterface

// File: rtl/fmdsp_core_mult.sv
// Combinational N x N signed multiplier; Baugh-Wooley array or radix-4 Booth.
module fmdsp_core_mult
    import fmdsp_pkg::*;
#(
    parameter int unsigned N        = 9,
    parameter int unsigned PPM_TYPE = PPM_BW
) (
    input  logic signed [N-1:0]   a_i,
    input  logic signed [N-1:0]   b_i,
    output logic signed [2*N-1:0] p_o
);
    localparam int NI = int'(N);
    // Booth needs an even multiplier width; sign-extend by one bit when N is odd.
    localparam int NB = NI + (NI % 2);

    if (PPM_TYPE == PPM_BOOTH) begin : g_booth
        // Radix-4 Booth recoding: one signed digit in {-2..2} per multiplier bit pair.
        always_comb begin
            logic signed [NB-1:0]   bs;
            logic        [NB:0]     bx;
            logic signed [2*NI-1:0] ax;
            logic signed [2*NI-1:0] pp;
            logic signed [2*NI-1:0] sum;
            logic        [2:0]      trip;
            bs  = b_i;
            bx  = {bs, 1'b0};
            ax  = a_i;
            sum = '0;
            for (int k = 0; k < NB / 2; k++) begin
                trip = bx[2*k+2 -: 3];
                case (trip)
                    3'b001, 3'b010: pp = ax;
                    3'b011:         pp = ax <<< 1;
                    3'b100:         pp = -(ax <<< 1);
                    3'b101, 3'b110: pp = -ax;
                    default:        pp = '0;
                endcase
                sum = sum + (pp << (2 * k));
            end
            p_o = sum;
        end
    end else begin : g_bw
        // Baugh-Wooley: sign-row/column partial bits inverted, correction 2^N + 2^(2N-1).
        always_comb begin
            logic [2*NI-1:0] sum;
            logic [2*NI-1:0] term;
            logic            pbit;
            sum          = '0;
            sum[NI]      = 1'b1;
            sum[2*NI-1]  = 1'b1;
            for (int i = 0; i < NI; i++) begin
                for (int j = 0; j < NI; j++) begin
                    pbit = a_i[i] & b_i[j];
                    if ((i == NI - 1) != (j == NI - 1)) pbit = ~pbit;
                    term        = '0;
                    term[i + j] = pbit;
                    sum         = sum + term;
                end
            end
            p_o = sum;
        end
    end

endmodule

// File: rtl/fmdsp_dsp_top.sv
// Fracturable signed multiply / multiply-add / MAC built on one (WIDTH/2+1)-bit core multiplier.
module fmdsp_dsp_top
    import fmdsp_pkg::*;
#(
    parameter int unsigned WIDTH            = 16,
    parameter int unsigned PPM_TYPE         = 0,
    parameter int unsigned SHIFT_BITS       = 2,
    parameter int unsigned PIPE_STAGE_WIDTH = 2,
    parameter int unsigned PIPELINE_BITS    = 2
) (
    input logic    clk,
    input logic    rst,
    fmdsp_if.slave bus
);
    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned PW = 2 * (H + 1);

    state_e                   state_q, state_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [1:0]               mode_q;
    logic [WIDTH-1:0]         aa_q, bb_q;
    logic [W2-1:0]            cc_q;
    logic                     mac_q, sh_en_q, sh_dir_q;
    logic [SHIFT_BITS-1:0]    sh_amt_q;
    logic [PIPELINE_BITS-1:0] pipe_en_q;
    logic [W2-1:0]            psum_q, acc_q, res_q;
    logic [W2-1:0]            pipe_q  [PIPELINE_BITS];
    logic [W2-1:0]            pipe_in [PIPELINE_BITS];

    logic                     last_pass, accept;
    logic [2:0]               last_idx;
    logic                     ia, ib;
    logic signed [H:0]        a_sel, b_sel;
    logic signed [PW-1:0]     prod;
    logic signed [W2-1:0]     prod_sx;
    logic [W2-1:0]            term, sum_next, acc_next, res_next, out_w;

    // Pass sequencing; a new start is taken when idle or on the final pass (back-to-back).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_idx  = num_passes(mode_q) - 3'd1;
        last_pass = (state_q == StRun) && ({1'b0, cnt_q} == last_idx);
        accept    = bus.start && ((state_q == StIdle) || last_pass);
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    cnt_d   = 2'd0;
                end
            end
            StRun: begin
                if (last_pass) begin
                    state_d = accept ? StRun : StIdle;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and pass counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture operands and controls at an accepted start; they stay fixed for the whole op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q    <= MODE_HH;
            aa_q      <= '0;
            bb_q      <= '0;
            cc_q      <= '0;
            mac_q     <= 1'b0;
            sh_en_q   <= 1'b0;
            sh_amt_q  <= '0;
            sh_dir_q  <= 1'b0;
            pipe_en_q <= '0;
        end else if (accept) begin
            mode_q    <= bus.mode;
            aa_q      <= bus.aa;
            bb_q      <= bus.bb;
            cc_q      <= bus.cc;
            mac_q     <= bus.mac;
            sh_en_q   <= bus.shift_enable;
            sh_amt_q  <= bus.shift_amount;
            sh_dir_q  <= bus.shift_dir;
            pipe_en_q <= bus.pipe_stages[PIPELINE_BITS-1:0];
        end
    end

    // Operand-half selection: low halves zero-extended, high halves sign-extended.
    always_comb begin
        unique case (mode_q)
            MODE_HH: begin ia = 1'b0;     ib = 1'b0;     end
            MODE_HF: begin ia = 1'b0;     ib = cnt_q[0]; end
            default: begin ia = cnt_q[1]; ib = cnt_q[0]; end
        endcase
        if (mode_q == MODE_HH || mode_q == MODE_HF) a_sel = aa_q[H:0];
        else if (ia)                                a_sel = {aa_q[WIDTH-1], aa_q[WIDTH-1:H]};
        else                                        a_sel = {1'b0, aa_q[H-1:0]};
        if (mode_q == MODE_HH) b_sel = bb_q[H:0];
        else if (ib)           b_sel = {bb_q[WIDTH-1], bb_q[WIDTH-1:H]};
        else                   b_sel = {1'b0, bb_q[H-1:0]};
    end

    fmdsp_core_mult #(
        .N        (H + 1),
        .PPM_TYPE (PPM_TYPE)
    ) u_mult (
        .a_i (a_sel),
        .b_i (b_sel),
        .p_o (prod)
    );

    // Weight the pass product, accumulate the partial sum, fold in acc/cc, apply the output shift.
    always_comb begin
        prod_sx = prod;
        unique case ({ia, ib})
            2'b00:   term = prod_sx;
            2'b11:   term = prod_sx << (2 * H);
            default: term = prod_sx << H;
        endcase
        sum_next = ((cnt_q == 2'd0) ? '0 : psum_q) + term;
        acc_next = (mac_q ? acc_q : '0) + sum_next + cc_q;
        res_next = acc_next;
        if (sh_en_q) begin
            if (sh_dir_q) res_next = $signed(acc_next) >>> sh_amt_q;
            else          res_next = acc_next << sh_amt_q;
        end
    end

    // Partial sum every pass; accumulator and unshifted-by-acc result on the last pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psum_q <= '0;
            acc_q  <= '0;
            res_q  <= '0;
        end else if (state_q == StRun) begin
            psum_q <= sum_next;
            if (last_pass) begin
                acc_q <= acc_next;
                res_q <= res_next;
            end
        end
    end

    // Optional output registers; a disabled stage is bypassed.
    always_comb begin
        logic [W2-1:0] tap;
        tap = res_q;
        for (int i = 0; i < int'(PIPELINE_BITS); i++) begin
            pipe_in[i] = tap;
            if (pipe_en_q[i]) tap = pipe_q[i];
        end
        out_w = tap;
    end

    // Output pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(PIPELINE_BITS); i++) pipe_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(PIPELINE_BITS); i++) pipe_q[i] <= pipe_in[i];
        end
    end

    assign bus.out = out_w;

endmodule

// File: tb/tb_fmdsp_dsp_top.sv
// Directed and randomised checks of fmdsp_dsp_top (Baugh-Wooley and Booth instances side by side).
module tb_fmdsp_dsp_top;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] prev = '0;
    logic [31:0] macc;

    always #5 clk = ~clk;

    fmdsp_if #(.WIDTH(16), .SHIFT_BITS(2), .PIPE_STAGE_WIDTH(2)) bus ();
    fmdsp_if #(.WIDTH(16), .SHIFT_BITS(2), .PIPE_STAGE_WIDTH(2)) bus2 ();

    assign bus2.start        = bus.start;
    assign bus2.mode         = bus.mode;
    assign bus2.aa           = bus.aa;
    assign bus2.bb           = bus.bb;
    assign bus2.cc           = bus.cc;
    assign bus2.mac          = bus.mac;
    assign bus2.shift_enable = bus.shift_enable;
    assign bus2.shift_amount = bus.shift_amount;
    assign bus2.shift_dir    = bus.shift_dir;
    assign bus2.pipe_stages  = bus.pipe_stages;

    fmdsp_dsp_top #(
        .WIDTH(16), .PPM_TYPE(0), .SHIFT_BITS(2), .PIPE_STAGE_WIDTH(2), .PIPELINE_BITS(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fmdsp_dsp_top #(
        .WIDTH(16), .PPM_TYPE(1), .SHIFT_BITS(2), .PIPE_STAGE_WIDTH(2), .PIPELINE_BITS(2)
    ) dut_booth (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic [31:0] exp);
        check(tag, bus.out, exp);
        check({tag, "_booth"}, bus2.out, exp);
    endtask

    task automatic drive(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] c, input logic mc, input logic se,
                         input logic [1:0] sa, input logic sd, input logic [1:0] ps);
        bus.mode         = m;
        bus.aa           = a;
        bus.bb           = b;
        bus.cc           = c;
        bus.mac          = mc;
        bus.shift_enable = se;
        bus.shift_amount = sa;
        bus.shift_dir    = sd;
        bus.pipe_stages  = ps;
    endtask

    function automatic int passes(input logic [1:0] m);
        return (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
    endfunction

    // Start one op, optionally confirm out still holds the old value one cycle early.
    task automatic run_op(input string tag, input logic [1:0] m, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] c, input logic mc,
                          input logic se, input logic [1:0] sa, input logic sd,
                          input logic [1:0] ps, input logic [31:0] exp, input bit early);
        int lat;
        lat = passes(m) + int'(ps[0]) + int'(ps[1]);
        @(negedge clk);
        drive(m, a, b, c, mc, se, sa, sd, ps);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (lat - 1) @(negedge clk);
        if (early) check_both({tag, "_early"}, prev);
        @(negedge clk);
        check_both(tag, exp);
        prev = exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  m;
        logic [15:0] a, b;
        logic [31:0] c, accn, r;
        logic        mc, se, sd;
        logic [1:0]  sa, ps;
        longint      pa, pb;

        bus.start = 1'b0;
        drive(2'd0, '0, '0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_both("reset", 32'h0);
        rst = 1'b1;

        // Mode 0 and output pipeline latency.
        run_op("m0_neg",   2'd0, 16'hFFFD, 16'd7, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'hFFFFFFEB, 1);
        run_op("m0_pipe1", 2'd0, 16'd3,    16'd7, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd1, 32'd21, 1);
        run_op("m0_pipe2", 2'd0, 16'hFFFD, 16'd7, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd2, 32'hFFFFFFEB, 1);
        run_op("m0_pipe3", 2'd0, 16'd5,    16'd7, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd3, 32'd35, 1);

        // Reset in the middle of a mode-2 op.
        @(negedge clk);
        drive(2'd2, 16'h1234, 16'h5678, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_both("rst_mid", 32'h0);
        @(negedge clk);
        rst  = 1'b1;
        prev = '0;
        run_op("post_rst_mac", 2'd0, 16'd2, 16'd3, 32'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'd6, 1);

        // Mode 2 corner values.
        run_op("m2_minmin", 2'd2, 16'h8000, 16'h8000, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h40000000, 1);
        run_op("m2_maxmin", 2'd2, 16'h7FFF, 16'h8000, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'hC0008000, 1);

        // Mode 1 accumulate.
        run_op("clr1",   2'd0, 16'd0, 16'd0,     32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0, 0);
        run_op("m1_mac1", 2'd1, 16'd5, 16'h1234, 32'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'd23300, 1);
        run_op("m1_mac2", 2'd1, 16'd5, 16'h1234, 32'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'd46600, 1);

        // Mode 0 accumulate with a negative operand.
        run_op("clr2",    2'd0, 16'd0,    16'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0, 0);
        run_op("m0_acc1", 2'd0, 16'd100,  16'd1, 32'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'd100, 1);
        run_op("m0_acc2", 2'd0, 16'hFFE2, 16'd1, 32'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'd70, 1);

        // Shifter; the shift must not reach the accumulator.
        run_op("shl",     2'd0, 16'd3, 16'd4, 32'd10,        1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 32'd88, 1);
        run_op("shr",     2'd0, 16'd3, 16'd4, 32'd10,        1'b0, 1'b1, 2'd2, 1'b1, 2'd0, 32'd5, 1);
        run_op("shr_neg", 2'd0, 16'd3, 16'd4, 32'hFFFFFFD8,  1'b0, 1'b1, 2'd2, 1'b1, 2'd0, 32'hFFFFFFF9, 1);
        run_op("acc_unsh", 2'd0, 16'd0, 16'd0, 32'd0,        1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'hFFFFFFE4, 1);

        // Back-to-back: second start lands exactly 4 cycles after a mode-2 start.
        @(negedge clk);
        drive(2'd2, 16'h7FFF, 16'h7FFF, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        drive(2'd0, 16'd2, 16'd3, 32'd1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_both("b2b_first", 32'h3FFF0001);
        @(negedge clk);
        check_both("b2b_second", 32'h3FFF0008);

        // Start during a busy mode-2 op is dropped.
        @(negedge clk);
        drive(2'd2, 16'd2, 16'd3, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        drive(2'd0, 16'd100, 16'd1, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check_both("busy_start_res", 32'd6);
        repeat (4) @(negedge clk);
        check_both("busy_start_hold", 32'd6);
        prev = 32'd6;
        macc = 32'd6;

        // Random operations against a direct-multiply model.
        for (int n = 0; n < 60; n++) begin
            m  = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (m < 2'd2)  a = {{7{a[8]}}, a[8:0]};
            if (m == 2'd0) b = {{7{b[8]}}, b[8:0]};
            c  = $urandom;
            mc = (n == 0) ? 1'b0 : 1'($urandom);
            se = 1'($urandom);
            sa = 2'($urandom);
            sd = 1'($urandom);
            ps = {1'b0, 1'($urandom)};
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            accn = (mc ? macc : 32'd0) + 32'(pa * pb) + c;
            macc = accn;
            r = accn;
            if (se) begin
                if (sd) r = $signed(accn) >>> sa;
                else    r = accn << sa;
            end
            run_op($sformatf("rand%0d_m%0d", n, m), m, a, b, c, mc, se, sa, sd, ps, r, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
